// File: rtl/guess_scorekeeper.sv
// Game-control stage behind guess_FSM: paces its LED rotation with an en tick,
// keeps BCD win/loss scores, raises speed on win streaks and ends the game on losses.
module guess_scorekeeper #(
  parameter int BASE_DIV     = 25000000,
  parameter int MAX_LOSSES   = 3,
  parameter int SPEEDUP_WINS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       win,
  input  logic       lose,
  output logic       en,
  output logic [7:0] wins_bcd,
  output logic [3:0] losses_bcd,
  output logic [1:0] level,
  output logic       playing,
  output logic       game_over
);

  localparam int DW = $clog2(BASE_DIV);
  localparam logic [DW-1:0] LIM0 = DW'(BASE_DIV - 1);
  localparam logic [DW-1:0] LIM1 = DW'((BASE_DIV >> 1) - 1);
  localparam logic [DW-1:0] LIM2 = DW'((BASE_DIV >> 2) - 1);
  localparam logic [DW-1:0] LIM3 = DW'((BASE_DIV >> 3) - 1);

  typedef enum logic [1:0] {IDLE, PLAY, RESULT, OVER} state_e;

  state_e        state_q, state_d;
  logic          start_s1_q, start_s2_q, start_s3_q;
  logic          win_q, win_prev_q, lose_q, lose_prev_q;
  logic [DW-1:0] div_q, div_d, div_lim;
  logic          en_q, en_d;
  logic [7:0]    wins_q, wins_d, wins_inc;
  logic [3:0]    losses_q, losses_d, losses_inc;
  logic [1:0]    level_q, level_d;
  logic [3:0]    streak_q, streak_d, streak_inc;
  logic          playing_q, game_over_q;
  logic          start_rise, win_rise, lose_rise;

  // Start is asynchronous to clk; win/lose come from guess_FSM and only need edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1_q  <= 1'b0;
      start_s2_q  <= 1'b0;
      start_s3_q  <= 1'b0;
      win_q       <= 1'b0;
      win_prev_q  <= 1'b0;
      lose_q      <= 1'b0;
      lose_prev_q <= 1'b0;
    end else begin
      start_s1_q  <= start;
      start_s2_q  <= start_s1_q;
      start_s3_q  <= start_s2_q;
      win_q       <= win;
      win_prev_q  <= win_q;
      lose_q      <= lose;
      lose_prev_q <= lose_q;
    end
  end

  assign start_rise = start_s2_q & ~start_s3_q;
  assign win_rise   = win_q & ~win_prev_q;
  assign lose_rise  = lose_q & ~lose_prev_q;

  assign streak_inc = streak_q + 4'd1;
  assign losses_inc = losses_q + 4'd1;

  always_comb begin
    wins_inc = wins_q;
    if (wins_q != 8'h99) begin
      if (wins_q[3:0] == 4'd9) wins_inc = {wins_q[7:4] + 4'd1, 4'd0};
      else                     wins_inc = {wins_q[7:4], wins_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    case (level_q)
      2'd0:    div_lim = LIM0;
      2'd1:    div_lim = LIM1;
      2'd2:    div_lim = LIM2;
      default: div_lim = LIM3;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    en_d     = 1'b0;
    wins_d   = wins_q;
    losses_d = losses_q;
    level_d  = level_q;
    streak_d = streak_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          wins_d   = 8'h00;
          losses_d = 4'h0;
          level_d  = 2'd0;
          streak_d = 4'd0;
          div_d    = '0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        // A loss wins any tie with a simultaneous win.
        if (lose_rise) begin
          losses_d = losses_inc;
          streak_d = 4'd0;
          div_d    = '0;
          state_d  = (losses_inc == 4'(MAX_LOSSES)) ? OVER : RESULT;
        end else if (win_rise) begin
          wins_d = wins_inc;
          if (streak_inc == 4'(SPEEDUP_WINS)) begin
            streak_d = 4'd0;
            if (level_q != 2'd3) level_d = level_q + 2'd1;
          end else begin
            streak_d = streak_inc;
          end
          div_d   = '0;
          state_d = RESULT;
        end else if (div_q == div_lim) begin
          en_d  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      RESULT: begin
        div_d = '0;
        if (!win_q && !lose_q) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      en_q        <= 1'b0;
      wins_q      <= 8'h00;
      losses_q    <= 4'h0;
      level_q     <= 2'd0;
      streak_q    <= 4'd0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      en_q        <= en_d;
      wins_q      <= wins_d;
      losses_q    <= losses_d;
      level_q     <= level_d;
      streak_q    <= streak_d;
      playing_q   <= (state_d == PLAY) || (state_d == RESULT);
      game_over_q <= (state_d == OVER);
    end
  end

  assign en         = en_q;
  assign wins_bcd   = wins_q;
  assign losses_bcd = losses_q;
  assign level      = level_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_guess_scorekeeper.sv
// Bench for guess_scorekeeper: directed game scenarios plus random play, all checked
// every cycle against a score/mode model built from the game rules.
module tb_guess_scorekeeper;

  localparam int BASE_DIV     = 8;
  localparam int MAX_LOSSES   = 3;
  localparam int SPEEDUP_WINS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       en;
  logic [7:0] wins_bcd;
  logic [3:0] losses_bcd;
  logic [1:0] level;
  logic       playing;
  logic       game_over;

  int checks = 0;
  int failures = 0;
  bit cmpOn = 0;

  guess_scorekeeper #(
    .BASE_DIV(BASE_DIV), .MAX_LOSSES(MAX_LOSSES), .SPEEDUP_WINS(SPEEDUP_WINS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .win(win), .lose(lose),
    .en(en), .wins_bcd(wins_bcd), .losses_bcd(losses_bcd), .level(level),
    .playing(playing), .game_over(game_over)
  );

  initial forever #5 clk = ~clk;

  typedef enum {M_IDLE, M_PLAY, M_RESULT, M_OVER} mode_e;
  mode_e mMode = M_IDLE;
  int mWins = 0, mLosses = 0, mLevel = 0, mStreak = 0, mPhase = 0;
  bit mEn = 0;
  bit sH1, sH2, sH3, wH1, wH2, lH1, lH2;
  bit sRise, wRise, lRise;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: game rules in plain integers, clocked by the sampled inputs.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mMode = M_IDLE; mWins = 0; mLosses = 0; mLevel = 0; mStreak = 0; mPhase = 0; mEn = 0;
      sH1 = 0; sH2 = 0; sH3 = 0; wH1 = 0; wH2 = 0; lH1 = 0; lH2 = 0;
    end else begin
      sRise = sH2 && !sH3;
      wRise = wH1 && !wH2;
      lRise = lH1 && !lH2;
      mEn = 0;
      case (mMode)
        M_IDLE, M_OVER: if (sRise) begin
          mWins = 0; mLosses = 0; mLevel = 0; mStreak = 0; mPhase = 0; mMode = M_PLAY;
        end
        M_PLAY: begin
          if (lRise) begin
            mLosses++; mStreak = 0;
            mMode = (mLosses == MAX_LOSSES) ? M_OVER : M_RESULT;
          end else if (wRise) begin
            if (mWins < 99) mWins++;
            mStreak++;
            if (mStreak == SPEEDUP_WINS) begin
              mStreak = 0;
              if (mLevel < 3) mLevel++;
            end
            mMode = M_RESULT;
          end else begin
            mPhase++;
            mEn = (mPhase % (BASE_DIV >> mLevel)) == 0;
          end
        end
        M_RESULT: if (!wH1 && !lH1) begin
          mMode = M_PLAY; mPhase = 0;
        end
        default: mMode = M_IDLE;
      endcase
      sH3 = sH2; sH2 = sH1; sH1 = start;
      wH2 = wH1; wH1 = win;
      lH2 = lH1; lH1 = lose;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmpOn) begin
      checkOutput("en", en, mEn);
      checkOutput("wins_bcd", wins_bcd, (mWins / 10) * 16 + mWins % 10);
      checkOutput("losses_bcd", losses_bcd, mLosses);
      checkOutput("level", level, mLevel);
      checkOutput("playing", playing, (mMode == M_PLAY || mMode == M_RESULT) ? 1 : 0);
      checkOutput("game_over", game_over, (mMode == M_OVER) ? 1 : 0);
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic applyStimulus(input bit s, input bit w, input bit l, input int len);
    start = s; win = w; lose = l;
    stepCycles(len);
    start = 0; win = 0; lose = 0;
  endtask

  task automatic winPulse();
    applyStimulus(0, 1, 0, 3);
    stepCycles(5);
  endtask

  task automatic losePulse();
    applyStimulus(0, 0, 1, 3);
    stepCycles(5);
  endtask

  task automatic firstEnDelay(output int d);
    int t = 0;
    start = 1;
    @(negedge clk);
    while (!playing && t < 20) begin @(negedge clk); t++; end
    d = 0;
    do begin @(negedge clk); d++; end while (!en && d < 40);
    if (t >= 20) d = -1;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic measurePeriod(output int p);
    int t = 0;
    @(negedge clk);
    while (!en && t < 40) begin @(negedge clk); t++; end
    p = 0;
    do begin @(negedge clk); p++; end while (!en && p < 40);
    if (t >= 40) p = -1;
    @(posedge clk); #2;
  endtask

  task automatic asyncResetCheck();
    @(posedge clk); #3;
    reset = 0;
    #1;
    checkOutput("rstEn", en, 0);
    checkOutput("rstWins", wins_bcd, 8'h00);
    checkOutput("rstLosses", losses_bcd, 0);
    checkOutput("rstLevel", level, 0);
    checkOutput("rstPlaying", playing, 0);
    checkOutput("rstOver", game_over, 0);
    @(posedge clk); #2;
    reset = 1;
    stepCycles(2);
  endtask

  initial begin
    int d, p, cnt, r;
    #1 reset = 0;
    cmpOn = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleEn", en, 0);
    checkOutput("idleWins", wins_bcd, 8'h00);
    checkOutput("idlePlaying", playing, 0);
    #1 reset = 1;
    stepCycles(2);

    $display("[TB] reset and start");
    firstEnDelay(d);
    checkOutput("firstEn", d, 8);
    checkOutput("playing", playing, 1);
    measurePeriod(p);
    checkOutput("period0", p, 8);

    $display("[TB] speed-up");
    winPulse();
    winPulse();
    checkOutput("twoWins", wins_bcd, 8'h02);
    checkOutput("level1", level, 1);
    measurePeriod(p);
    checkOutput("period1", p, 4);
    applyStimulus(0, 1, 0, 20);
    stepCycles(5);
    checkOutput("heldWin", wins_bcd, 8'h03);

    $display("[TB] BCD carry and saturation");
    repeat (6) winPulse();
    checkOutput("wins09", wins_bcd, 8'h09);
    winPulse();
    checkOutput("wins10", wins_bcd, 8'h10);
    repeat (90) winPulse();
    checkOutput("wins99", wins_bcd, 8'h99);
    checkOutput("level3", level, 3);
    measurePeriod(p);
    checkOutput("period3", p, 1);

    $display("[TB] async reset mid-play");
    asyncResetCheck();

    $display("[TB] loss path");
    firstEnDelay(d);
    winPulse();
    losePulse();
    winPulse();
    checkOutput("lossLevel", level, 0);
    checkOutput("lossCount", losses_bcd, 1);
    checkOutput("lossWins", wins_bcd, 8'h02);

    $display("[TB] game over");
    losePulse();
    losePulse();
    checkOutput("overFlag", game_over, 1);
    checkOutput("overLosses", losses_bcd, 3);
    cnt = 0;
    repeat (50) begin @(negedge clk); if (en) cnt++; end
    checkOutput("overNoEn", cnt, 0);
    checkOutput("overWinsFrozen", wins_bcd, 8'h02);
    @(posedge clk); #2;
    firstEnDelay(d);
    checkOutput("restartFirstEn", d, 8);
    checkOutput("restartOver", game_over, 0);
    checkOutput("restartWins", wins_bcd, 8'h00);
    checkOutput("restartLosses", losses_bcd, 0);
    measurePeriod(p);
    checkOutput("restartPeriod", p, 8);

    $display("[TB] simultaneous win and lose");
    applyStimulus(0, 1, 1, 3);
    stepCycles(5);
    checkOutput("bothLosses", losses_bcd, 1);
    checkOutput("bothWins", wins_bcd, 8'h00);

    $display("[TB] random play");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      stepCycles($urandom_range(1, 6));
      else if (r < 75) applyStimulus(0, 1, 0, $urandom_range(1, 4));
      else if (r < 85) applyStimulus(0, 0, 1, $urandom_range(1, 4));
      else if (r < 91) applyStimulus(0, 1, 1, $urandom_range(1, 3));
      else if (r < 98) applyStimulus(1, 0, 0, $urandom_range(1, 3));
      else             asyncResetCheck();
      if (r >= 50 && r < 98) stepCycles($urandom_range(0, 5));
    end

    stepCycles(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_scorekeeper.md
Name: guess_scorekeeper

Overview:
- Game-control stage directly downstream of guess_FSM. It consumes guess_FSM's win/lose levels and produces the en tick that paces guess_FSM's LED rotation.
- Keeps BCD win/loss scores and a win-streak speed level that shortens the tick period.
- Ends the game after a set number of losses.
- Sits between guess_FSM and the seven-segment display driver.

Parameters:
- BASE_DIV, 25000000: clk cycles per en pulse at level 0; must be divisible by 8.
- MAX_LOSSES, 3: losses that end the game; range 1..9.
- SPEEDUP_WINS, 4: consecutive wins needed to raise the level; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw start/restart button; synchronized internally with 2 flops.
- win  input  1  win level from guess_FSM.
- lose  input  1  lose level from guess_FSM.
- en  output  1  single-cycle tick to guess_FSM en.
- wins_bcd  output  8  win count; two BCD digits, [7:4] tens, [3:0] ones.
- losses_bcd  output  4  loss count; one BCD digit.
- level  output  2  speed level 0..3.
- playing  output  1  high in PLAY and RESULT.
- game_over  output  1  high in OVER.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - State IDLE.
  - en=0, wins_bcd=8'h00, losses_bcd=4'h0, level=0, streak=0, divider=0.
  - playing=0, game_over=0; edge-detect registers cleared.
- **Edge detection**:
  - start_rise = sync2 & ~sync3, taken from the synchronizer chain.
  - win_rise and lose_rise = cur & ~prev, using registered copies of win and lose.
  - Only rising edges score. Held levels never count twice.
- **State IDLE**: en=0.
  - On start_rise: clear scores, level and streak; divider=0; go to PLAY.
- **State PLAY**: divider increments every cycle.
  - DIV = BASE_DIV >> level.
  - en=1 for exactly the cycle where divider==DIV-1; divider then wraps to 0.
  - The first en occurs DIV cycles after entering PLAY.
  - On win_rise:
    - wins_bcd increments in BCD (09->10, 99 saturates at 99); streak+1.
    - If streak+1==SPEEDUP_WINS: streak=0, and level+1 if level<3; at level 3 it holds at 3.
    - Go to RESULT.
  - On lose_rise:
    - losses_bcd+1 and streak=0; level unchanged.
    - If the new loss count == MAX_LOSSES go to OVER, else go to RESULT.
  - Simultaneous win_rise and lose_rise: treated as lose only; wins unchanged.
  - en is suppressed (0) in the cycle a rise is detected; divider resets to 0.
  - start_rise in PLAY is ignored.
- **State RESULT**: en=0, divider held at 0.
  - Return to PLAY in the cycle after win==0 and lose==0 are both sampled.
  - start_rise is ignored.
- **State OVER**: en=0, game_over=1; scores and level frozen for display.
  - On start_rise: clear scores, level and streak; go to PLAY.
- **Register timing**: all outputs are registered. Scores update on the clock edge that also changes state, one cycle after the win/lose edge is sampled.
- **Reset mid-game**: asynchronous return to IDLE with all reset values above; no partial score retained.

Test Plan (BASE_DIV=8, MAX_LOSSES=3, SPEEDUP_WINS=2):
- **Reset and start.** Reset low then high; start pulse.
  - Required: IDLE with en=0 and all outputs zero.
  - After the synchronizer delay: playing=1, and en pulses once every 8 cycles, first pulse 8 cycles after entering PLAY.
- **Speed-up.** Two wins, each a 3-cycle win pulse with gaps.
  - Required: wins_bcd=8'h02, level=1, en period 4 cycles.
  - Holding win high for 20 cycles adds only one win; PLAY resumes only after win drops.
- **BCD carry and saturation.** Drive 10 wins.
  - Required: wins_bcd goes 8'h09->8'h10.
  - Continue to 99 plus 1: holds 8'h99. Level saturates at 3 (period 1 cycle).
- **Loss path.** One win, then a loss.
  - Required: streak cleared, so the next single win does not raise level; losses_bcd=4'h1.
- **Game over.**
  - Third loss: game_over=1, en stays 0 for 50 cycles, scores frozen.
  - Start pulse: game_over=0, scores 0, level 0, en period 8.
- **Edge cases.**
  - Win and lose rising in the same cycle: only losses_bcd increments.
  - reset asserted mid-PLAY between clock edges: outputs clear immediately, before the next clk edge.
